// File: rtl/btn_cmd_scheduler.sv
// Push-button front end: per-button sync, debounce and press capture, then a
// round-robin arbiter issuing one valid/ready command per debounced press.
module btn_cmd_scheduler #(
    parameter  int N_BTN           = 4,
    parameter  int DEBOUNCE_CYCLES = 1000000,
    localparam int IW              = $clog2(N_BTN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BTN-1:0]  btn_in,
    output logic              cmd_valid,
    output logic [IW-1:0]     cmd_id,
    input  logic              cmd_ready,
    output logic [N_BTN-1:0]  pending,
    output logic              overrun
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [IW-1:0]        cmd_id_reg;
    logic [IW-1:0]        cmd_id_next;
    logic [IW-1:0]        last_grant_reg;
    logic [IW-1:0]        last_grant_next;
    logic [N_BTN-1:0]     pending_reg;
    logic [N_BTN-1:0]     pending_next;
    logic                 overrun_reg;
    logic [N_BTN-1:0]     press_vec;
    logic [N_BTN-1:0]     clr_vec;
    logic [N_BTN-1:0]     ovr_vec;
    logic                 handshake;

    logic [2*N_BTN-1:0]   pend_dbl;
    logic [2*N_BTN-1:0]   pend_shift;
    logic [N_BTN-1:0]     pend_rot;
    logic                 grant_found;
    logic [IW-1:0]        grant_idx;
    int                   grant_off;
    int                   grant_sum;

    assign handshake = (state_reg == ST_OFFER) && cmd_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic          s1_reg;
            logic          s2_reg;
            logic          db_reg;
            logic [CW-1:0] cnt_reg;
            logic          settle;

            // Level accepted once it has differed from db for DEBOUNCE_CYCLES samples in a row.
            assign settle = (s2_reg != db_reg) && (cnt_reg == CW'(DEBOUNCE_CYCLES - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg  <= 1'b0;
                    s2_reg  <= 1'b0;
                    db_reg  <= 1'b0;
                    cnt_reg <= '0;
                end else begin
                    s1_reg <= btn_in[gi];
                    s2_reg <= s1_reg;
                    if (s2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (settle) begin
                        db_reg  <= s2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press_vec[gi]    = settle & s2_reg;
            assign clr_vec[gi]      = handshake && (cmd_id_reg == IW'(gi));
            // A press on the same edge as its own handshake re-arms the bit without overrun.
            assign ovr_vec[gi]      = press_vec[gi] & ~clr_vec[gi] & pending_reg[gi];
            assign pending_next[gi] = press_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    // Rotate pending so that bit 0 is the button just after the last grant.
    assign pend_dbl   = {pending_reg, pending_reg};
    assign pend_shift = pend_dbl >> (int'(last_grant_reg) + 1);
    assign pend_rot   = pend_shift[N_BTN-1:0];

    always_comb begin
        grant_found = |pending_reg;
        grant_off   = 0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            if (pend_rot[k]) begin
                grant_off = k;
            end
        end
        grant_sum = int'(last_grant_reg) + 1 + grant_off;
        if (grant_sum >= N_BTN) begin
            grant_sum = grant_sum - N_BTN;
        end
        grant_idx = IW'(grant_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cmd_id_reg     <= '0;
            last_grant_reg <= IW'(N_BTN - 1);
            pending_reg    <= '0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cmd_id_reg     <= cmd_id_next;
            last_grant_reg <= last_grant_next;
            pending_reg    <= pending_next;
            overrun_reg    <= |ovr_vec;
        end
    end

    // Once offered, cmd_id is frozen until the consumer takes it.
    always_comb begin
        state_next      = state_reg;
        cmd_id_next     = cmd_id_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_found) begin
                    state_next  = ST_OFFER;
                    cmd_id_next = grant_idx;
                end
            end
            ST_OFFER: begin
                if (cmd_ready) begin
                    state_next      = ST_IDLE;
                    last_grant_next = cmd_id_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_valid = (state_reg == ST_OFFER);
        cmd_id    = cmd_id_reg;
        pending   = pending_reg;
        overrun   = overrun_reg;
    end

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// Bench for btn_cmd_scheduler: directed latency/reset cases plus randomized
// bouncing buttons and backpressure checked against a behavioural model.
module tb_btn_cmd_scheduler;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int IW = $clog2(N);

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic [N-1:0]  btn_in    = '0;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid;
    logic [IW-1:0] cmd_id;
    logic [N-1:0]  pending;
    logic          overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_cmds   = 0;

    // Model: sync delay line, window of recent synced samples, debounced level,
    // pending set, and the offer currently on the channel.
    logic [N-1:0] m_sync_q[$];
    logic [N-1:0] m_win[$];
    logic [N-1:0] m_db;
    logic [N-1:0] m_pend;
    bit           m_offer;
    int           m_id;
    int           m_last;
    bit           m_ovr;

    btn_cmd_scheduler #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_in(btn_in),
        .cmd_valid(cmd_valid),
        .cmd_id(cmd_id),
        .cmd_ready(cmd_ready),
        .pending(pending),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sync_q = {};
        m_sync_q.push_back('0);
        m_sync_q.push_back('0);
        m_win = {};
        for (int i = 0; i < D; i++) m_win.push_back('0);
        m_db    = '0;
        m_pend  = '0;
        m_offer = 1'b0;
        m_id    = 0;
        m_last  = N - 1;
        m_ovr   = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] b, input bit rdy);
        logic [N-1:0] x;
        logic [N-1:0] press;
        logic [N-1:0] clr;
        logic [N-1:0] pend_pre;
        x = m_sync_q[0];
        void'(m_sync_q.pop_front());
        m_sync_q.push_back(b);
        m_win.push_back(x);
        if (m_win.size() > D) void'(m_win.pop_front());
        press = '0;
        for (int j = 0; j < N; j++) begin
            bit all_diff = 1'b1;
            foreach (m_win[i]) if (m_win[i][j] == m_db[j]) all_diff = 1'b0;
            if (all_diff) begin
                press[j] = ~m_db[j];
                m_db[j]  = ~m_db[j];
            end
        end
        clr = (m_offer && rdy) ? (N'(1) << m_id) : '0;
        pend_pre = m_pend;
        m_ovr  = |(press & pend_pre & ~clr);
        m_pend = (pend_pre & ~clr) | press;
        if (m_offer) begin
            if (rdy) begin
                m_offer = 1'b0;
                m_last  = m_id;
                n_cmds++;
                $display("txn %0d: cmd_id=%0d accepted at t=%0t", n_cmds, m_id, $time);
            end
        end else if (pend_pre != '0) begin
            for (int k = 1; k <= N; k++) begin
                int idx = (m_last + k) % N;
                if (pend_pre[idx]) begin
                    m_id = idx;
                    break;
                end
            end
            m_offer = 1'b1;
        end
    endtask

    task automatic compare();
        check("valid", 32'(cmd_valid), 32'(m_offer));
        if (m_offer) check("id", 32'(cmd_id), 32'(m_id));
        check("pending", 32'(pending), 32'(m_pend));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic step();
        logic [N-1:0] b;
        bit r;
        b = btn_in;
        r = cmd_ready;
        @(posedge clk);
        model_edge(b, r);
        #1;
        compare();
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_valid", 32'(cmd_valid), 32'd0);
        check("rst_async_pending", 32'(pending), 32'd0);
        check("rst_async_overrun", 32'(overrun), 32'd0);
        repeat (cycles) @(posedge clk);
        #1;
        compare();
        rst_n = 1'b1;
    endtask

    // Explicit latency from a clean rise (or reset release) to the single offer.
    task automatic latency_run(input int id);
        for (int e = 0; e < 10; e++) begin
            step();
            check("lat_valid", 32'(cmd_valid), 32'(e == 6));
            if (e == 6) check("lat_id", 32'(cmd_id), 32'(id));
            check("lat_pend", 32'(pending[id]), 32'(e == 5 || e == 6));
        end
    endtask

    initial begin
        logic [N-1:0] tgt;
        logic [N-1:0] nb;
        int hold[N];
        int bnc[N];
        int hold_max;
        int bnc_max;
        int rdy_pct;
        int waited;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare();
        rst_n = 1'b1;

        cmd_ready = 1'b1;
        btn_in[2] = 1'b1;
        latency_run(2);
        for (int i = 0; i < 10; i++) step();
        btn_in[2] = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Re-press btn 2 with the consumer stalled, then reset during the offer.
        cmd_ready = 1'b0;
        btn_in[2] = 1'b1;
        waited = 0;
        while (!m_offer && waited < 20) begin
            step();
            waited++;
        end
        check("offer_before_reset", 32'(cmd_valid), 32'd1);
        apply_reset(3);
        cmd_ready = 1'b1;
        latency_run(2);
        btn_in = '0;
        for (int i = 0; i < 10; i++) step();

        tgt = '0;
        for (int j = 0; j < N; j++) begin
            hold[j] = $urandom_range(1, 20);
            bnc[j]  = 0;
        end
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: begin hold_max = 40; bnc_max = 0; rdy_pct = 100; end
                1: begin hold_max = 30; bnc_max = 6; rdy_pct = 70;  end
                2: begin hold_max = 25; bnc_max = 3; rdy_pct = 15;  end
                default: begin hold_max = 12; bnc_max = 8; rdy_pct = 50; end
            endcase
            for (int c = 0; c < 4000; c++) begin
                for (int j = 0; j < N; j++) begin
                    if (hold[j] == 0) begin
                        tgt[j]  = ~tgt[j];
                        hold[j] = $urandom_range(1, hold_max);
                        bnc[j]  = $urandom_range(0, bnc_max);
                    end else begin
                        hold[j]--;
                    end
                    if (bnc[j] > 0) begin
                        nb[j] = 1'($urandom_range(0, 1));
                        bnc[j]--;
                    end else begin
                        nb[j] = tgt[j];
                    end
                end
                btn_in    = nb;
                cmd_ready = ($urandom_range(0, 99) < rdy_pct);
                if ($urandom_range(0, 1999) == 0) apply_reset($urandom_range(1, 3));
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_cmd_scheduler.md
Name: btn_cmd_scheduler

Overview:
Front-end controller for the board push-buttons. Per button it synchronises, debounces and edge-detects the raw input, and records each press in a pending flag. A round-robin arbiter shares one valid/ready command channel among the buttons, so the mode/menu logic receives exactly one command per debounced press.

Parameters:
N_BTN, 4, number of buttons (2..8); cmd_id width IW = $clog2(N_BTN)
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles needed to accept a level change (10 ms at 100 MHz); benches use 4

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
btn_in  in  N_BTN  raw asynchronous button levels, 1 = pressed
cmd_valid  out  1  command offered
cmd_id  out  IW  index of the button being offered
cmd_ready  in  1  consumer accepts when high together with cmd_valid
pending  out  N_BTN  per-button press waiting to be issued
overrun  out  1  one-cycle pulse when a press finds its pending bit already set

Behaviour:
- Reset (rst_n low, async) clears sync FFs, debounce counters, debounced levels db, pending, cmd_valid, cmd_id and overrun. Last-grant register resets to N_BTN-1, so button 0 has first priority.
- Sync: two FFs per bit, s1 <= btn_in, s2 <= s1.
- Debounce per bit: if s2 == db, cnt <= 0. Otherwise cnt <= cnt+1. When cnt == DEBOUNCE_CYCLES-1 and s2 != db, db <= s2 and cnt <= 0. Any bounce back to db restarts the count.
- Press event: the edge at which db goes 0->1. Releases (1->0) generate nothing.
- Pending per bit, evaluated each edge:
  - press and bit not being cleared this edge: if pending already 1, overrun = 1 for one cycle and pending stays 1 (no queueing); else pending <= 1.
  - handshake on this bit without a press: pending <= 0.
  - handshake and press on the same edge: pending stays 1, no overrun.
- Arbiter FSM, two states:
  - IDLE: cmd_valid = 0. If pending != 0, select the first set bit searching upward from last_grant+1 with wrap. Register cmd_id, set cmd_valid, go to OFFER.
  - OFFER: cmd_valid = 1. cmd_id is held stable and is not re-arbitrated, even if higher-priority bits become pending. On cmd_valid & cmd_ready: clear that pending bit, last_grant <= cmd_id, cmd_valid <= 0, go to IDLE.
  - Maximum throughput is one command per 2 cycles.
  - cmd_ready is ignored while cmd_valid is low.
- Latency: btn_in stable high before edge 0 (clean transition) -> s2 = 1 after edge 1 -> db and pending set at edge 1+DEBOUNCE_CYCLES -> cmd_valid high after edge 2+DEBOUNCE_CYCLES (edge 6 for DEBOUNCE_CYCLES = 4).
- Reset mid-operation:
  - An offered command is dropped and cmd_valid falls immediately.
  - A button held through reset sees db = 0 after reset and generates one fresh press. cmd_valid rises after edge 2+DEBOUNCE_CYCLES, counting from the first edge after rst_n deasserts.
- The counter is wide enough for DEBOUNCE_CYCLES-1 and never wraps.

Test Plan:
1. DEBOUNCE_CYCLES = 4, N_BTN = 4, cmd_ready = 1: btn_in[2] rises cleanly and is held -> cmd_valid = 1 with cmd_id = 2 exactly after edge 6, for one cycle. pending[2] = 1 during edges 5–6 and 0 after. No further commands while held or on release.
2. Bounce: btn_in[1] pattern 1,1,1,0 repeated 5 times, then held 1 -> no command during bouncing. Exactly one command, cmd_id = 1, DEBOUNCE_CYCLES+3 edges after the final rise. overrun never pulses.
3. Round-robin: press btn 1 alone and accept it (last_grant = 1). Then press btns 0 and 2 on the same cycle with cmd_ready = 1 -> cmd_id = 2 first, then cmd_id = 0 two cycles later. pending returns to 0.
4. Backpressure: cmd_ready = 0 while btn 3 is offered. Release and re-press btn 3 (debounced) during the stall -> cmd_valid/cmd_id = 3 held stable, overrun pulses exactly one cycle, pending[3] stays 1. Raise cmd_ready -> exactly one command issued.
5. Simultaneous clear/set: arrange btn 0 press event on the same edge its offer handshakes -> pending[0] stays 1, overrun = 0, and a second cmd_id = 0 follows two cycles later.
6. Reset mid-offer: with cmd_valid = 1 and btn 2 held, pulse rst_n low for 3 cycles -> cmd_valid, pending, overrun go 0 asynchronously. After release, cmd_id = 2 is offered after edge 6 counted from deassertion.
